// File: rtl/dsc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsc_pkg
// Brief    : Shared widths, tag type and index helper for the path-search core.
// Revision : 1.0
// ============================================================================
package dsc_pkg;

  localparam int ADDR_WIDTH          = 10;
  localparam int CUSTO_WIDTH         = 3;
  localparam int MAX_VIZINHOS        = 8;
  localparam int RELACOES_DATA_WIDTH = MAX_VIZINHOS * (ADDR_WIDTH + CUSTO_WIDTH);
  localparam int NUM_NA              = 8;
  localparam int NA_ID_WIDTH         = $clog2(NUM_NA);

  typedef struct packed {
    logic                   valid;
    logic [NA_ID_WIDTH-1:0] id;
  } tag_t;

  // (base + off) mod n for base < n and off <= n, without relying on power-of-two wrap
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_prioridade.sv
`default_nettype none
// ============================================================================
// Module   : rr_prioridade
// Brief    : Combinational round-robin picker; searches ptr+1 .. ptr+N mod N.
// Revision : 1.0
// ============================================================================
module rr_prioridade #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] id_o,
  output logic           any_gnt_o
);
  import dsc_pkg::*;

  int             idx;
  logic [IDW-1:0] idx_l;

  always_comb begin
    gnt_o     = '0;
    id_o      = '0;
    any_gnt_o = 1'b0;
    idx       = 0;
    idx_l     = '0;
    for (int k = 1; k <= N; k++) begin
      idx   = wrap_add(int'(ptr_i), k, N);
      idx_l = IDW'(idx);
      if (!any_gnt_o && req_i[idx_l]) begin
        gnt_o[idx_l] = 1'b1;
        id_o         = idx_l;
        any_gnt_o    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbitro_relacoes.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_relacoes
// Brief    : Round-robin sharing of the relations-memory read port with tagged returns.
// Revision : 1.0
// ============================================================================
module arbitro_relacoes #(
  parameter int NUM_NA              = dsc_pkg::NUM_NA,
  parameter int ADDR_WIDTH          = dsc_pkg::ADDR_WIDTH,
  parameter int RELACOES_DATA_WIDTH = dsc_pkg::RELACOES_DATA_WIDTH,
  parameter int MEM_LATENCY         = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_in,
  input  logic [NUM_NA-1:0]                req_in,
  input  logic [NUM_NA*ADDR_WIDTH-1:0]     addr_in,
  output logic [NUM_NA-1:0]                gnt_out,
  output logic                             mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0]            mem_addr_out,
  input  logic [RELACOES_DATA_WIDTH-1:0]   mem_data_in,
  output logic [NUM_NA-1:0]                rd_valid_out,
  output logic [RELACOES_DATA_WIDTH-1:0]   rd_data_out
);
  import dsc_pkg::*;

  localparam int             IDW     = $clog2(NUM_NA);
  localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_NA - 1);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } stage_tag_t;

  logic [IDW-1:0]                 ptr_q, ptr_d;
  logic [NUM_NA-1:0]              req_eff, gnt;
  logic [IDW-1:0]                 win_id;
  logic                           any_gnt;
  stage_tag_t [MEM_LATENCY-1:0]   tag_q, tag_d;
  logic                           ret_fire;
  logic [NUM_NA-1:0]              rd_valid_q, rd_valid_d;
  logic [RELACOES_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0]          addr_mux;

  // Reset and flush both mask requests so nothing is issued without a tag slot.
  assign req_eff = (rst || flush_in) ? '0 : req_in;

  rr_prioridade #(
    .N   (NUM_NA),
    .IDW (IDW)
  ) u_rr (
    .req_i     (req_eff),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .id_o      (win_id),
    .any_gnt_o (any_gnt)
  );

  always_comb begin
    addr_mux = '0;
    for (int i = 0; i < NUM_NA; i++) begin
      if (gnt[i]) addr_mux = addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign gnt_out       = gnt;
  assign mem_rd_en_out = any_gnt;
  assign mem_addr_out  = addr_mux;

  always_comb begin
    ptr_d = ptr_q;
    if (flush_in)     ptr_d = PTR_RST;
    else if (any_gnt) ptr_d = win_id;
  end

  always_comb begin
    tag_d = tag_q;
    for (int k = MEM_LATENCY - 1; k > 0; k--) begin
      tag_d[k] = tag_q[k-1];
    end
    tag_d[0].valid = any_gnt;
    tag_d[0].id    = win_id;
    if (flush_in) begin
      for (int k = 0; k < MEM_LATENCY; k++) tag_d[k].valid = 1'b0;
    end
  end

  assign ret_fire = tag_q[MEM_LATENCY-1].valid & ~flush_in;

  always_comb begin
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    if (ret_fire) begin
      rd_valid_d = NUM_NA'(1) << tag_q[MEM_LATENCY-1].id;
      rd_data_d  = mem_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= PTR_RST;
      tag_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tag_q      <= tag_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_out = rd_valid_q;
  assign rd_data_out  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_relacoes.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_relacoes
// Brief    : Directed self-checking bench for arbitro_relacoes (MEM_LATENCY=1).
// Revision : 1.0
// ============================================================================
module tb_arbitro_relacoes;

  localparam int N  = 8;
  localparam int AW = 10;
  localparam int DW = 104;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush_in = 1'b0;
  logic [N-1:0]    req_in = '0;
  logic [N*AW-1:0] addr_in = '0;
  logic [N-1:0]    gnt_out;
  logic            mem_rd_en_out;
  logic [AW-1:0]   mem_addr_out;
  logic [DW-1:0]   mem_data_in;
  logic [N-1:0]    rd_valid_out;
  logic [DW-1:0]   rd_data_out;

  int n_cmp = 0;
  int n_err = 0;

  arbitro_relacoes #(
    .NUM_NA              (N),
    .ADDR_WIDTH          (AW),
    .RELACOES_DATA_WIDTH (DW),
    .MEM_LATENCY         (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_in      (flush_in),
    .req_in        (req_in),
    .addr_in       (addr_in),
    .gnt_out       (gnt_out),
    .mem_rd_en_out (mem_rd_en_out),
    .mem_addr_out  (mem_addr_out),
    .mem_data_in   (mem_data_in),
    .rd_valid_out  (rd_valid_out),
    .rd_data_out   (rd_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {8{a, a[2:0] ^ 3'b101}};
  endfunction

  // One-cycle-latency memory model
  always @(posedge clk or posedge rst) begin
    if (rst)                mem_data_in <= '0;
    else if (mem_rd_en_out) mem_data_in <= word_of(mem_addr_out);
  end

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs(input int base);
    for (int i = 0; i < N; i++) addr_in[i*AW +: AW] = AW'(base + i);
  endtask

  logic [N-1:0] exp_g4 [4];

  initial begin
    exp_g4 = '{8'h04, 8'h20, 8'h04, 8'h20};

    // Reset state; grants suppressed while rst is high
    req_in = 8'h01;
    #12;
    chk_eq("rst_gnt",   gnt_out, 0);
    chk_eq("rst_valid", rd_valid_out, 0);
    chk_eq("rst_data",  rd_data_out, 0);
    req_in = '0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single request from unit 0
    set_addrs(0);
    addr_in[0 +: AW] = 10'd12;
    req_in = 8'h01;
    #1;
    chk_eq("t1_gnt",   gnt_out, 8'h01);
    chk_eq("t1_rden",  mem_rd_en_out, 1);
    chk_eq("t1_addr",  mem_addr_out, 12);
    step();
    req_in = '0;
    #1;
    chk_eq("t1_v_early", rd_valid_out, 0);
    step();
    chk_eq("t1_valid", rd_valid_out, 8'h01);
    chk_eq("t1_data",  rd_data_out, word_of(10'd12));
    step();
    chk_eq("t1_v_once", rd_valid_out, 0);
    chk_eq("t1_hold",   rd_data_out, word_of(10'd12));
    step();

    // All units requesting; ptr=0 so order starts at 1 and wraps 7->0
    set_addrs(100);
    for (int s = 0; s < 12; s++) begin
      req_in = (s < 10) ? 8'hFF : 8'h00;
      #1;
      if (s < 10) begin
        chk_eq("all_gnt",  gnt_out, 8'h01 << ((1 + s) % 8));
        chk_eq("all_addr", mem_addr_out, 100 + ((1 + s) % 8));
      end else begin
        chk_eq("all_idle", gnt_out, 0);
      end
      if (s >= 2) begin
        chk_eq("all_valid", rd_valid_out, 8'h01 << ((s - 1) % 8));
        chk_eq("all_data",  rd_data_out, word_of(AW'(100 + ((s - 1) % 8))));
      end else begin
        chk_eq("all_v0", rd_valid_out, 0);
      end
      step();
    end

    // Grant to 6, then units 2 and 5 alternate
    req_in = 8'h40;
    #1;
    chk_eq("g6_gnt", gnt_out, 8'h40);
    step();
    for (int j = 0; j < 4; j++) begin
      req_in = 8'h24;
      #1;
      chk_eq("p25_gnt", gnt_out, exp_g4[j]);
      step();
    end
    req_in = '0;
    step(); step(); step();

    // Three grants then flush; ptr was 5
    set_addrs(200);
    req_in = 8'h13;
    #1;
    chk_eq("f_g1", gnt_out, 8'h01);
    step();
    chk_eq("f_g2", gnt_out, 8'h02);
    step();
    chk_eq("f_g3", gnt_out, 8'h10);
    chk_eq("f_v1", rd_valid_out, 8'h01);
    chk_eq("f_d1", rd_data_out, word_of(10'd200));
    step();
    flush_in = 1'b1;
    #1;
    chk_eq("f_gnt",  gnt_out, 0);
    chk_eq("f_rden", mem_rd_en_out, 0);
    chk_eq("f_v2",   rd_valid_out, 8'h02);
    chk_eq("f_d2",   rd_data_out, word_of(10'd201));
    step();
    flush_in = 1'b0;
    req_in   = 8'h48;
    #1;
    chk_eq("pf_gnt3", gnt_out, 8'h08);
    chk_eq("pf_drop", rd_valid_out, 0);
    step();
    chk_eq("pf_gnt6", gnt_out, 8'h40);
    chk_eq("pf_v0",   rd_valid_out, 0);
    step();
    req_in = '0;
    #1;
    chk_eq("pf_v3", rd_valid_out, 8'h08);
    chk_eq("pf_d3", rd_data_out, word_of(10'd203));
    step();
    chk_eq("pf_v6", rd_valid_out, 8'h40);
    chk_eq("pf_d6", rd_data_out, word_of(10'd206));
    step();
    chk_eq("pf_vend", rd_valid_out, 0);

    // Asynchronous reset with a read in flight; ptr was 6
    set_addrs(300);
    req_in = 8'h06;
    #1;
    chk_eq("ar_g1", gnt_out, 8'h02);
    step();
    chk_eq("ar_g2", gnt_out, 8'h04);
    step();
    req_in = '0;
    #1;
    chk_eq("ar_v1", rd_valid_out, 8'h02);
    chk_eq("ar_d1", rd_data_out, word_of(10'd301));
    #2;
    rst = 1'b1;
    #1;
    chk_eq("ar_v_now", rd_valid_out, 0);
    chk_eq("ar_d_now", rd_data_out, 0);
    req_in = 8'h10;
    #1;
    chk_eq("ar_gnt_rst", gnt_out, 0);
    @(posedge clk);
    #3;
    rst    = 1'b0;
    req_in = '0;
    for (int j = 0; j < 3; j++) begin
      step();
      #1;
      chk_eq("ar_no_ret", rd_valid_out, 0);
    end
    req_in = 8'h82;
    #1;
    chk_eq("ar_ptr7", gnt_out, 8'h02);
    chk_eq("ar_addr", mem_addr_out, 301);
    step();
    req_in = '0;
    step();
    chk_eq("ar_v_new", rd_valid_out, 8'h02);
    chk_eq("ar_d_new", rd_data_out, word_of(10'd301));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
